phase_err_det: RTL and testbench
================================

PHASE_ERR_DET -- requirements
Module: phase_err_det

Interface
REQ-001 The block SHALL provide parameter ERR_W, default 8: width of the signed phase-error word. Legal range is 4..16.
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 0: number of input synchroniser flops per input. Legal range is 0..3.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 en  input  1  measurement enable.
REQ-006 ref_signal  input  1  reference clock/pulse.
REQ-007 ctrl_signal  input  1  DCO feedback signal.
REQ-008 ref_rise  output  1  combinational rising-edge strobe of the synchronised ref.
REQ-009 lead  output  1  one-cycle pulse: ctrl edge preceded ref edge.
REQ-010 lag  output  1  one-cycle pulse: ref edge preceded ctrl edge.
REQ-011 err_valid  output  1  one-cycle pulse: phase_err updated this cycle.
REQ-012 phase_err  output  ERR_W  signed two's-complement error in clk cycles; holds its value between updates.
REQ-013 err_sat  output  1  one-cycle pulse with err_valid when |phase_err| == MAX_CNT.
REQ-014 freq_up  output  1  one-cycle pulse: two ref edges occurred without a ctrl edge (ctrl too slow).
REQ-015 freq_dn  output  1  one-cycle pulse: two ctrl edges occurred without a ref edge (ctrl too fast).

Function
REQ-016 Each input SHALL pass through SYNC_STAGES flops, then one delay flop (_d1). rise = (d1==0 && sync==1), using sync = the raw input when SYNC_STAGES=0.
REQ-017 ref_rise SHALL equal the ref rise term combinationally. ctrl_rise is internal.
REQ-018 MAX_CNT SHALL be 2^(ERR_W-1)-1. The cycle counter SHALL saturate at MAX_CNT and never wrap.
REQ-019 The FSM SHALL have three states: IDLE, WAIT_CTRL (ref opened the window), WAIT_REF (ctrl opened the window).
REQ-020 In IDLE:
- ref_rise and ctrl_rise in the same cycle -> emit 0 with lead=lag=0, stay IDLE.
- ref_rise only -> WAIT_CTRL with cnt=1.
- ctrl_rise only -> WAIT_REF with cnt=1.
REQ-021 In WAIT_CTRL, each cycle without a closing edge SHALL do cnt = min(cnt+1, MAX_CNT).
REQ-022 In WAIT_CTRL, ctrl_rise SHALL emit +cnt with lag=1.
- With no simultaneous ref_rise -> IDLE.
- With a simultaneous ref_rise -> WAIT_CTRL with cnt=1.
REQ-023 In WAIT_CTRL, ref_rise without ctrl_rise SHALL emit +MAX_CNT with err_sat=1 and freq_up=1, lag=0, then WAIT_CTRL with cnt=1.
REQ-024 WAIT_REF SHALL mirror WAIT_CTRL:
- ref_rise emits -cnt with lead=1.
- A repeated ctrl_rise emits -MAX_CNT with err_sat=1 and freq_dn=1.
- A simultaneous ctrl_rise reopens WAIT_REF with cnt=1.
REQ-025 "Emit" SHALL mean: on the next clk edge, register phase_err and the listed pulses, with err_valid=1. The output latency is exactly 1 cycle after the edge-detect cycle.
REQ-026 lead, lag, err_valid, err_sat, freq_up and freq_dn SHALL be 0 in every cycle with no emit.
REQ-027 lead and lag SHALL never both be 1 in the same cycle. freq_up and freq_dn SHALL never both be 1 in the same cycle.
REQ-028 While en=0:
- The FSM is forced to IDLE and cnt to 0.
- No pulses are emitted and phase_err holds its value.
- The synchroniser and _d1 flops keep running.
REQ-029 When en deasserts mid-window, the window SHALL be discarded without an emit.
REQ-030 When en asserts, an edge in that same cycle SHALL be processed normally.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously clear every flop: synchronisers, _d1, FSM to IDLE, cnt=0, phase_err=0, and all pulse outputs to 0.
REQ-032 ref_rise SHALL be 0 while in reset.
REQ-033 A reset asserted mid-window SHALL discard the window. After release, the first edge SHALL open a new window from IDLE.

Verification
REQ-034 The bench SHALL cover lag: ERR_W=8, SYNC_STAGES=0, en=1. ref rises at cycle 10 and ctrl at cycle 13 -> cycle 14 shows err_valid=1, lag=1, phase_err=+3 (0x03).
REQ-035 The bench SHALL cover lead: ctrl rises at cycle 10 and ref at cycle 15 -> cycle 16 shows err_valid=1, lead=1, phase_err=-5 (0xFB).
REQ-036 The bench SHALL cover coincident edges: ref and ctrl rise in the same cycle -> next cycle shows err_valid=1, phase_err=0, lead=lag=0.
REQ-037 The bench SHALL cover frequency detection: ref rises at cycles 10 and 30 with no ctrl edge -> cycle 31 shows freq_up=1, err_sat=1, phase_err=+127 (0x7F). A ctrl rise at cycle 34 then yields phase_err=+4 at cycle 35.
REQ-038 The bench SHALL cover saturation and enable:
- ref rises, ctrl rises 200 cycles later -> phase_err=+127 with err_sat=1.
- Repeated with en dropped for one cycle mid-window -> no emit at all.
REQ-039 The bench SHALL cover reset mid-window: rst_n pulsed low in WAIT_CTRL -> all outputs 0 immediately. After release, ctrl rises then ref rises 2 cycles later -> phase_err=-2 with lead=1.

Source files
------------

// File: rtl/phase_err_det.sv
// Bang-bang / linear phase-error detector between a reference and a DCO
// feedback signal, with saturating cycle counter and frequency flags.
module phase_err_det #(
    parameter int ERR_W       = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    ref_signal,
    input  logic                    ctrl_signal,
    output logic                    ref_rise,
    output logic                    lead,
    output logic                    lag,
    output logic                    err_valid,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_sat,
    output logic                    freq_up,
    output logic                    freq_dn
);
    localparam int CW = ERR_W - 1;
    localparam logic [CW-1:0] MAX_CNT = {CW{1'b1}};
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic signed [ERR_W-1:0] MAX_POS = {1'b0, MAX_CNT};
    localparam logic signed [ERR_W-1:0] MAX_NEG = {1'b1, {(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT_CTRL, WAIT_REF} state_t;

    // bit 0 carries ref, bit 1 carries ctrl
    logic [1:0] raw, sync, d1, rise;
    assign raw = {ctrl_signal, ref_signal};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = raw;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][1:0] ff;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ff <= '0;
                end else begin
                    ff[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        ff[i] <= ff[i-1];
                    end
                end
            end
            assign sync = ff[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d1 <= '0;
        else        d1 <= sync;
    end

    assign rise = sync & ~d1;
    logic ref_r, ctrl_r;
    assign ref_r  = rise[0];
    assign ctrl_r = rise[1];
    assign ref_rise = ref_r & rst_n;

    state_t state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt, cnt_inc;
    logic signed [ERR_W-1:0] pos, neg, emit_val;
    logic emit, emit_lead, emit_lag, emit_up, emit_dn, emit_sat;

    assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + ONE;
    assign pos = {1'b0, cnt};
    assign neg = ERR_W'(0) - pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        emit      = 1'b0;
        emit_val  = '0;
        emit_lead = 1'b0;
        emit_lag  = 1'b0;
        emit_up   = 1'b0;
        emit_dn   = 1'b0;
        if (!en) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ref_r && ctrl_r) begin
                        emit = 1'b1;
                    end else if (ref_r) begin
                        nxt_state = WAIT_CTRL;
                        nxt_cnt   = ONE;
                    end else if (ctrl_r) begin
                        nxt_state = WAIT_REF;
                        nxt_cnt   = ONE;
                    end
                end
                WAIT_CTRL: begin
                    if (ctrl_r) begin
                        emit     = 1'b1;
                        emit_val = pos;
                        emit_lag = 1'b1;
                        if (ref_r) begin
                            nxt_cnt = ONE;
                        end else begin
                            nxt_state = IDLE;
                            nxt_cnt   = '0;
                        end
                    end else if (ref_r) begin
                        // second ref edge with no ctrl edge: ctrl is slow
                        emit     = 1'b1;
                        emit_val = MAX_POS;
                        emit_up  = 1'b1;
                        nxt_cnt  = ONE;
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                end
                WAIT_REF: begin
                    if (ref_r) begin
                        emit      = 1'b1;
                        emit_val  = neg;
                        emit_lead = 1'b1;
                        if (ctrl_r) begin
                            nxt_cnt = ONE;
                        end else begin
                            nxt_state = IDLE;
                            nxt_cnt   = '0;
                        end
                    end else if (ctrl_r) begin
                        emit     = 1'b1;
                        emit_val = MAX_NEG;
                        emit_dn  = 1'b1;
                        nxt_cnt  = ONE;
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        emit_sat = emit && ((emit_val == MAX_POS) || (emit_val == MAX_NEG));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            lead      <= 1'b0;
            lag       <= 1'b0;
            err_sat   <= 1'b0;
            freq_up   <= 1'b0;
            freq_dn   <= 1'b0;
            phase_err <= '0;
        end else begin
            err_valid <= emit;
            lead      <= emit_lead;
            lag       <= emit_lag;
            err_sat   <= emit_sat;
            freq_up   <= emit_up;
            freq_dn   <= emit_dn;
            if (emit) phase_err <= emit_val;
        end
    end
endmodule

// File: tb/tb_phase_err_det.sv
// Bench for phase_err_det: table-driven edge scenarios with a
// scoreboard of expected emits checked every cycle.
module tb_phase_err_det;
    logic clk = 1'b0;
    logic rst_n, en, ref_signal, ctrl_signal;
    logic ref_rise, lead, lag, err_valid, err_sat, freq_up, freq_dn;
    logic [7:0] phase_err;

    phase_err_det #(.ERR_W(8), .SYNC_STAGES(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .ref_signal(ref_signal), .ctrl_signal(ctrl_signal),
        .ref_rise(ref_rise), .lead(lead), .lag(lag),
        .err_valid(err_valid), .phase_err(phase_err),
        .err_sat(err_sat), .freq_up(freq_up), .freq_dn(freq_dn)
    );

    always #5 clk = ~clk;

    // flag order: {valid, lead, lag, sat, up, dn}
    localparam logic [5:0] F_LAG    = 6'b101000;
    localparam logic [5:0] F_LEAD   = 6'b110000;
    localparam logic [5:0] F_ZERO   = 6'b100000;
    localparam logic [5:0] F_SATLAG = 6'b101100;
    localparam logic [5:0] F_UP     = 6'b100110;
    localparam logic [5:0] F_DN     = 6'b100101;

    typedef struct {
        int         cyc;
        logic [5:0] fl;
        logic [7:0] err;
    } exp_t;

    typedef struct {
        string      name;
        int         ref0, ref1, ctrl0, ctrl1;
        int         en_off, pre_off, len;
        int         e0_cyc;
        logic [5:0] e0_fl;
        logic [7:0] e0_err;
        int         e1_cyc;
        logic [5:0] e1_fl;
        logic [7:0] e1_err;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    logic [7:0] last_err = 8'h00;
    logic [5:0] flags;
    assign flags = {err_valid, lead, lag, err_sat, freq_up, freq_dn};

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_on) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missed_emit_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("emit_flags", flags, e.fl);
                chk("emit_phase_err", phase_err, e.err);
                last_err = e.err;
            end else begin
                chk("idle_pulses", flags, 6'b0);
                chk("phase_err_hold", phase_err, last_err);
            end
        end
    end

    function automatic vec_t mk(string nm, int r0, int r1, int c0, int c1,
                                int eoff, int pre, int len,
                                int c_a, logic [5:0] f_a, logic [7:0] v_a,
                                int c_b, logic [5:0] f_b, logic [7:0] v_b);
        vec_t v;
        v.name = nm; v.ref0 = r0; v.ref1 = r1; v.ctrl0 = c0; v.ctrl1 = c1;
        v.en_off = eoff; v.pre_off = pre; v.len = len;
        v.e0_cyc = c_a; v.e0_fl = f_a; v.e0_err = v_a;
        v.e1_cyc = c_b; v.e1_fl = f_b; v.e1_err = v_b;
        return v;
    endfunction

    task automatic run_vec(vec_t v);
        int base;
        @(posedge clk); #1;
        base = cyc;
        if (v.e0_cyc >= 0) sb.push_back('{base + v.e0_cyc, v.e0_fl, v.e0_err});
        if (v.e1_cyc >= 0) sb.push_back('{base + v.e1_cyc, v.e1_fl, v.e1_err});
        for (int t = 0; t < v.len; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            ref_signal  = (t == v.ref0) || (t == v.ref1);
            ctrl_signal = (t == v.ctrl0) || (t == v.ctrl1);
            en = !((t < v.pre_off) || (t == v.en_off));
            if (ref_signal) begin
                #1 chk({v.name, "_ref_rise"}, ref_rise, 1'b1);
            end
        end
        ref_signal  = 1'b0;
        ctrl_signal = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mk("lag", 10, -1, 13, -1, -1, 2, 20,
                     14, F_LAG, 8'h03, -1, 6'b0, 8'h00);
        vecs[1] = mk("lead", 15, -1, 10, -1, -1, 2, 22,
                     16, F_LEAD, 8'hFB, -1, 6'b0, 8'h00);
        vecs[2] = mk("coincident", 10, -1, 10, -1, -1, 2, 15,
                     11, F_ZERO, 8'h00, -1, 6'b0, 8'h00);
        vecs[3] = mk("freq_up", 10, 30, 34, -1, -1, 2, 40,
                     31, F_UP, 8'h7F, 35, F_LAG, 8'h04);
        vecs[4] = mk("saturate", 10, -1, 210, -1, -1, 2, 215,
                     211, F_SATLAG, 8'h7F, -1, 6'b0, 8'h00);
        vecs[5] = mk("en_drop", 10, -1, 210, -1, 100, 2, 215,
                     -1, 6'b0, 8'h00, -1, 6'b0, 8'h00);
        vecs[6] = mk("freq_dn", 28, -1, 10, 25, -1, 2, 32,
                     26, F_DN, 8'h81, 29, F_LEAD, 8'hFD);
        vecs[7] = mk("reopen", 10, 14, 14, 17, -1, 2, 22,
                     15, F_LAG, 8'h04, 18, F_LAG, 8'h03);
        vecs[8] = mk("en_edge", 2, -1, 5, -1, -1, 2, 10,
                     6, F_LAG, 8'h03, -1, 6'b0, 8'h00);

        rst_n = 1'b0; en = 1'b0; ref_signal = 1'b0; ctrl_signal = 1'b0;
        repeat (3) @(posedge clk);
        #1 ref_signal = 1'b1;
        #1;
        chk("reset_flags", flags, 6'b0);
        chk("reset_phase_err", phase_err, 8'h00);
        chk("reset_ref_rise", ref_rise, 1'b0);
        ref_signal = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_on = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // open a window, then reset in the middle of it
        @(posedge clk); #1;
        en = 1'b1;
        ref_signal = 1'b1;
        @(posedge clk); #1;
        ref_signal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ref_signal = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midwin_reset_flags", flags, 6'b0);
        chk("midwin_reset_phase_err", phase_err, 8'h00);
        chk("midwin_reset_ref_rise", ref_rise, 1'b0);
        last_err = 8'h00;
        ref_signal = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(mk("after_reset", 4, -1, 2, -1, -1, 0, 10,
                   5, F_LEAD, 8'hFE, -1, 6'b0, 8'h00));

        repeat (4) @(posedge clk);
        #1 chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
